// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: single-step load/shift/rotate/clear by mode,
// plus an autonomous multi-step shift engine with busy/done handshake.
module universal_shift_register #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             serial_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out_msb,
    output logic             serial_out_lsb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [2:0] ModeHold = 3'b000;
    localparam logic [2:0] ModeLoad = 3'b001;
    localparam logic [2:0] ModeShl  = 3'b010;
    localparam logic [2:0] ModeShr  = 3'b011;
    localparam logic [2:0] ModeRol  = 3'b100;
    localparam logic [2:0] ModeRor  = 3'b101;
    localparam logic [2:0] ModeAsr  = 3'b110;

    localparam logic [CNT_W-1:0] MaxSteps = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] OneStep  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             shift_class;
    logic [CNT_W-1:0] count_clamped;

    function automatic logic [WIDTH-1:0] apply_step(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] pin,
        input logic             si
    );
        logic [WIDTH-1:0] r;
        case (m)
            ModeHold: r = d;
            ModeLoad: r = pin;
            ModeShl:  r = {d[WIDTH-2:0], si};
            ModeShr:  r = {si, d[WIDTH-1:1]};
            ModeRol:  r = {d[WIDTH-2:0], d[WIDTH-1]};
            ModeRor:  r = {d[0], d[WIDTH-1:1]};
            ModeAsr:  r = {d[WIDTH-1], d[WIDTH-1:1]};
            default:  r = '0;
        endcase
        return r;
    endfunction

    assign shift_class   = (mode >= ModeShl) && (mode <= ModeAsr);
    assign count_clamped = (count > MaxSteps) ? MaxSteps : count;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && shift_class && (count != '0)) begin
                    // Register holds on the accepting edge; steps begin on the next one.
                    state_d = StRun;
                    cnt_d   = count_clamped;
                    mode_d  = mode;
                    busy_d  = 1'b1;
                end else begin
                    data_d = apply_step(mode, data_q, parallel_in, serial_in);
                end
            end
            StRun: begin
                data_d = apply_step(mode_q, data_q, parallel_in, serial_in);
                cnt_d  = cnt_q - OneStep;
                if (cnt_q == OneStep) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= ModeHold;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign parallel_out   = data_q;
    assign serial_out_msb = data_q[WIDTH-1];
    assign serial_out_lsb = data_q[0];
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised successor to the 4-bit PIPO register. It adds configurable width, synchronous mode-selected operations (load, logical/arithmetic shift, rotate, clear), serial in/out, and an autonomous multi-step shift engine with busy/done handshake. It is the general-purpose data-holding and serialising register for the sequential library, used directly or as the core of SISO/SIPO/PISO variants.

## Interface
- WIDTH, 8, register width in bits; legal range ≥ 2.
- CNT_W, $clog2(WIDTH+1), width of the step-count port; derived, not overridden.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  3  operation select (encoding below).
- parallel_in  input  WIDTH  parallel load data.
- serial_in  input  1  bit inserted into the vacated position on logical shifts.
- start  input  1  request an autonomous run of `count` steps of the current `mode`.
- count  input  CNT_W  number of steps for an autonomous run.
- parallel_out  output  WIDTH  register contents.
- serial_out_msb  output  1  equals parallel_out[WIDTH-1].
- serial_out_lsb  output  1  equals parallel_out[0].
- busy  output  1  high while an autonomous run is in progress.
- done  output  1  one-cycle pulse when an autonomous run completes.

## Operation
- Mode encoding, one step:
  - 000 hold.
  - 001 load parallel_in.
  - 010 shift left, serial_in into bit 0.
  - 011 shift right, serial_in into bit WIDTH-1.
  - 100 rotate left.
  - 101 rotate right.
  - 110 arithmetic shift right; MSB is replicated and serial_in is ignored.
  - 111 clear to 0.
- "Shift-class" modes are 010–110.
- States: IDLE, RUN.
- IDLE:
  - When start=0, the mode step is applied at every clock edge.
  - When start=1, mode is shift-class and count≠0, the register holds at that edge. The block latches mode and min(count, WIDTH) into an internal step counter and goes to RUN.
  - When start=1 but mode is not shift-class, or count=0, start is ignored and the mode step is applied as for start=0.
- RUN:
  - One latched step is performed per edge and the counter decrements.
  - The mode, parallel_in, start and count inputs are ignored.
  - serial_in is sampled live at every step.
  - The edge that performs the final step returns the block to IDLE.
- done is registered. It is high for exactly the one cycle after the final step. It is never asserted outside a completed run.
- busy is registered. It is high from the cycle after start is accepted through the cycle in which the final step's edge occurs, so busy falls at the same edge where done rises.
- A count above WIDTH is clamped to WIDTH. Example: WIDTH rotates returns the original value.
- A start while busy=1 is ignored and is not queued.

## Timing
- Reset values: parallel_out=0, serial_out_msb=0, serial_out_lsb=0, busy=0, done=0, state IDLE, step counter 0.
- Reset has priority over everything. Asserting it mid-run aborts the run, leaves the data at 0, and produces no done.
- Single-step latency: the result is visible on parallel_out after one edge.
- Autonomous run with start accepted at edge E and N steps:
  - Steps occur at edges E+1 … E+N.
  - busy is high in the cycles following edges E … E+N-1.
  - done is high in the cycle following edge E+N.
  - The next start can be accepted at edge E+N+1, i.e. while done is high.
- Serial outputs are combinational copies of the register bits; no extra latency.

## Test plan
- Reset then load (WIDTH=8):
  - Stimulus: reset 2 cycles; mode=001, parallel_in=8'hA5 for one edge; then mode=000 for 3 cycles.
  - Response: parallel_out=8'h00 during reset; 8'hA5 after the load edge, held for 3 cycles; busy=0 and done=0 throughout.
- Single-step modes from 8'h81:
  - Each case starts from 8'h81 and applies one edge.
  - shift left, serial_in=1 → 8'h03.
  - shift right, serial_in=0 → 8'h40.
  - rotate left → 8'h03.
  - rotate right → 8'hC0.
  - arithmetic shift right → 8'hC0.
  - clear → 8'h00.
- Autonomous rotate:
  - Stimulus: load 8'h12; start=1, mode=101, count=4.
  - Response: busy high for 4 cycles; parallel_out=8'h21 with done high for one cycle; busy low.
- Serialise out:
  - Stimulus: load 8'hB4; start with mode=011, serial_in=0, count=8.
  - Response: serial_out_lsb before each step reads 0,0,1,0,1,1,0,1; final parallel_out=8'h00; done pulses once.
- Clamp and ignored start:
  - Stimulus: load 8'h3C; start with mode=100, count=15.
  - Response: exactly 8 steps, final value 8'h3C.
  - Stimulus: start with mode=001, or with count=0.
  - Response: no busy, no done; the start=1 cycle performs the mode's single step (load for 001; with count=0 the mode step is applied).
- Abort and re-issue:
  - Stimulus: start a count=6 run from 8'hFF; assert reset during its 3rd busy cycle.
  - Response: parallel_out=8'h00, busy=0, no done.
  - Stimulus: start again during busy.
  - Response: the second start is ignored; the counter is unaffected.
